// File: rtl/conway_gen_ctrl.sv
// Generation sequencer for the 8x8x8 Conway engine: free-run/step timing, seed load,
// display handshake, generation counting, extinction halt and engine timeout flag.
module conway_gen_ctrl #(
    parameter int unsigned TICK_DIV        = 25000000,
    parameter int unsigned TICK_W          = 25,
    parameter int unsigned GEN_W           = 16,
    parameter int unsigned TIMEOUT         = 1024,
    parameter int unsigned STOP_ON_EXTINCT = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Run,
    input  logic             Step_Req,
    input  logic             Load_Req,
    output logic             Gen_Start,
    input  logic             Gen_Done,
    input  logic             Extinct,
    output logic             Load_Start,
    input  logic             Load_Done,
    output logic             Frame_Req,
    input  logic             Frame_Ack,
    output logic [GEN_W-1:0] Gen_Count,
    output logic             Busy,
    output logic             Halted,
    output logic             Error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_GEN,
        S_LOAD,
        S_PRESENT,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GEN_W-1:0]   cnt_q, cnt_d;
    logic               halt_pend_q, halt_pend_d;
    logic               err_q, err_d;
    logic               gen_start_q, gen_start_d;
    logic               load_start_q, load_start_d;
    logic               frame_req_q, frame_req_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            tmo_q        <= '0;
            cnt_q        <= '0;
            halt_pend_q  <= 1'b0;
            err_q        <= 1'b0;
            gen_start_q  <= 1'b0;
            load_start_q <= 1'b0;
            frame_req_q  <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
            halt_pend_q  <= halt_pend_d;
            err_q        <= err_d;
            gen_start_q  <= gen_start_d;
            load_start_q <= load_start_d;
            frame_req_q  <= frame_req_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        tmo_d        = tmo_q;
        cnt_d        = cnt_q;
        halt_pend_d  = halt_pend_q;
        err_d        = err_q;
        gen_start_d  = 1'b0;
        load_start_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Load_Req) begin
                    state_d      = S_LOAD;
                    load_start_d = 1'b1;
                    tmo_d        = '0;
                end else if (Run) begin
                    state_d = S_WAIT_TICK;
                    presc_d = '0;
                end else if (Step_Req) begin
                    state_d     = S_GEN;
                    gen_start_d = 1'b1;
                    tmo_d       = '0;
                end
            end
            S_WAIT_TICK: begin
                if (Load_Req) begin
                    state_d      = S_LOAD;
                    load_start_d = 1'b1;
                    tmo_d        = '0;
                    presc_d      = '0;
                end else if (!Run) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end else if (presc_q == TICK_W'(TICK_DIV - 1)) begin
                    state_d     = S_GEN;
                    gen_start_d = 1'b1;
                    tmo_d       = '0;
                    presc_d     = '0;
                end else begin
                    presc_d = presc_q + TICK_W'(1);
                end
            end
            S_GEN: begin
                // done is checked before the timeout so a last-cycle done still succeeds
                if (Gen_Done) begin
                    state_d     = S_PRESENT;
                    cnt_d       = cnt_q + GEN_W'(1);
                    halt_pend_d = Extinct & (STOP_ON_EXTINCT != 0);
                    tmo_d       = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_LOAD: begin
                if (Load_Done) begin
                    state_d     = S_PRESENT;
                    cnt_d       = '0;
                    halt_pend_d = 1'b0;
                    tmo_d       = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_PRESENT: begin
                if (Frame_Ack) begin
                    if (halt_pend_q) begin
                        state_d = S_HALT;
                    end else if (Run) begin
                        state_d = S_WAIT_TICK;
                        presc_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (Load_Req) begin
                    state_d      = S_LOAD;
                    load_start_d = 1'b1;
                    tmo_d        = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        frame_req_d = (state_d == S_PRESENT);
        busy_d      = (state_d == S_LOAD) || (state_d == S_GEN) || (state_d == S_PRESENT);
        halted_d    = (state_d == S_HALT);
    end

    assign Gen_Start  = gen_start_q;
    assign Load_Start = load_start_q;
    assign Frame_Req  = frame_req_q;
    assign Gen_Count  = cnt_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign Error      = err_q;

endmodule

// File: tb/tb_conway_gen_ctrl.sv
// Table-driven bench for conway_gen_ctrl with small TICK_DIV/TIMEOUT/GEN_W values.
module tb_conway_gen_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Run = 1'b0, Step_Req = 1'b0, Load_Req = 1'b0;
    logic       Gen_Done = 1'b0, Extinct = 1'b0, Load_Done = 1'b0, Frame_Ack = 1'b0;
    logic       Gen_Start, Load_Start, Frame_Req, Busy, Halted, Error;
    logic [3:0] Gen_Count;

    conway_gen_ctrl #(
        .TICK_DIV(4),
        .TICK_W(3),
        .GEN_W(4),
        .TIMEOUT(8),
        .STOP_ON_EXTINCT(1)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step_Req(Step_Req), .Load_Req(Load_Req),
        .Gen_Start(Gen_Start), .Gen_Done(Gen_Done), .Extinct(Extinct),
        .Load_Start(Load_Start), .Load_Done(Load_Done), .Frame_Req(Frame_Req),
        .Frame_Ack(Frame_Ack), .Gen_Count(Gen_Count), .Busy(Busy), .Halted(Halted),
        .Error(Error)
    );

    always #5 Clk = ~Clk;

    // inputs {Run,Step,Load,Gen_Done,Extinct,Load_Done,Ack}; flags {GS,LS,FR,Busy,Halted,Error}
    localparam logic [6:0] I_NONE = 7'h00, I_RUN = 7'h40, I_STEP = 7'h20, I_LOAD = 7'h10,
                           I_GD = 7'h08, I_EXT = 7'h04, I_LD = 7'h02, I_ACK = 7'h01;
    localparam logic [5:0] F_GS = 6'h20, F_LS = 6'h10, F_FR = 6'h08, F_BSY = 6'h04,
                           F_HLT = 6'h02, F_ERR = 6'h01;

    typedef struct {
        logic [6:0] in;
        logic [5:0] fl;
        logic [3:0] cnt;
    } vec_t;

    vec_t vec[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic [6:0] i, input logic [5:0] f, input int unsigned c);
        vec_t v;
        v.in  = i;
        v.fl  = f;
        v.cnt = 4'(c);
        vec.push_back(v);
    endtask

    task automatic drive(input logic [6:0] i);
        {Run, Step_Req, Load_Req, Gen_Done, Extinct, Load_Done, Frame_Ack} = i;
    endtask

    task automatic check(input string name, input logic [5:0] f, input logic [3:0] c);
        logic [5:0] got;
        got = {Gen_Start, Load_Start, Frame_Req, Busy, Halted, Error};
        n_tests++;
        if (got !== f || Gen_Count !== c) begin
            n_fail++;
            $display("FAIL %s: flags(GS,LS,FR,BSY,HLT,ERR)=%b cnt=%0d, expected flags=%b cnt=%0d",
                     name, got, Gen_Count, f, c);
        end
    endtask

    task automatic cyc(input logic [6:0] i);
        drive(i);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int unsigned c;

        // step, gen, present, ack; stray done/ack in IDLE
        add(I_STEP, F_GS | F_BSY, 0);
        for (int i = 0; i < 3; i++) add(I_NONE, F_BSY, 0);
        add(I_GD, F_FR | F_BSY, 1);
        add(I_NONE, F_FR | F_BSY, 1);
        add(I_ACK, 6'h00, 1);
        add(I_GD | I_LD | I_ACK, 6'h00, 1);
        // load beats step; requests ignored while busy
        add(I_LOAD | I_STEP, F_LS | F_BSY, 1);
        add(I_STEP | I_LOAD, F_BSY, 1);
        add(I_LD, F_FR | F_BSY, 0);
        add(I_ACK, 6'h00, 0);
        // extinct -> halt; ack held high at present entry
        add(I_STEP, F_GS | F_BSY, 0);
        add(I_GD | I_EXT | I_ACK, F_FR | F_BSY, 1);
        add(I_ACK, F_HLT, 1);
        add(I_STEP | I_RUN, F_HLT, 1);
        add(I_RUN, F_HLT, 1);
        add(I_LOAD, F_LS | F_BSY, 1);
        add(I_LD, F_FR | F_BSY, 0);
        add(I_ACK, 6'h00, 0);
        // timeout after 8 GEN cycles; then done on cycle 8 wins
        add(I_STEP, F_GS | F_BSY, 0);
        for (int i = 0; i < 7; i++) add(I_NONE, F_BSY, 0);
        add(I_NONE, F_ERR, 0);
        add(I_STEP, F_GS | F_BSY | F_ERR, 0);
        for (int i = 0; i < 7; i++) add(I_NONE, F_BSY | F_ERR, 0);
        add(I_GD, F_FR | F_BSY | F_ERR, 1);
        add(I_ACK, F_ERR, 1);
        // free-run, TICK_DIV=4, done after 2 cycles, ack after 1
        c = 1;
        add(I_RUN, F_ERR, c);
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 3; i++) add(I_RUN, F_ERR, c);
            add(I_RUN, F_GS | F_BSY | F_ERR, c);
            add(I_RUN, F_BSY | F_ERR, c);
            c++;
            add(I_RUN | I_GD, F_FR | F_BSY | F_ERR, c);
            add(I_RUN | I_ACK, F_ERR, c);
        end
        add(I_RUN, F_ERR, 4);
        add(I_NONE, F_ERR, 4);
        for (int i = 0; i < 5; i++) add(I_NONE, F_ERR, 4);
        // counter wrap at GEN_W=4
        for (int k = 5; k <= 16; k++) begin
            add(I_STEP, F_GS | F_BSY | F_ERR, (k - 1) % 16);
            add(I_GD, F_FR | F_BSY | F_ERR, k % 16);
            add(I_ACK, F_ERR, k % 16);
        end

        repeat (3) @(posedge Clk);
        #1;
        check("reset", 6'h00, 4'd0);
        Rst_n = 1'b1;

        for (int i = 0; i < vec.size(); i++) begin
            cyc(vec[i].in);
            check($sformatf("vec%0d", i), vec[i].fl, vec[i].cnt);
        end

        // asynchronous reset mid-GEN, then a late Gen_Done
        cyc(I_STEP);
        check("pre_rst_step", F_GS | F_BSY | F_ERR, 4'd0);
        cyc(I_NONE);
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_rst", 6'h00, 4'd0);
        drive(I_GD);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        cyc(I_GD);
        check("late_done", 6'h00, 4'd0);
        cyc(I_NONE);
        check("post_rst_idle", 6'h00, 4'd0);
        cyc(I_STEP);
        check("post_rst_step", F_GS | F_BSY, 4'd0);
        cyc(I_GD);
        check("post_rst_done", F_FR | F_BSY, 4'd1);
        cyc(I_ACK);
        check("post_rst_ack", 6'h00, 4'd1);
        drive(I_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
